// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream generator.
//   lfsr_fsm_t      : generator control states
//   POLY32_DEFAULT  : recommended 32-bit tap mask for cfg_poly
//   POLY8_DEFAULT   : recommended 8-bit tap mask for cfg_poly
//   WIDTH_MIN/MAX   : supported range of the WIDTH parameter
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        LOCK = 2'd3
    } lfsr_fsm_t;

    localparam logic [31:0] POLY32_DEFAULT = 32'h80200003;
    localparam logic [7:0]  POLY8_DEFAULT  = 8'hB8;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational Fibonacci LFSR advance by STEPS shifts.
//   state      : current LFSR state
//   poly       : tap mask; feedback bit = XOR-reduce(state & poly)
//   next_state : state after STEPS shifts (new bit enters at bit 0)
module lfsr_step_unroll #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] next_state
);

    logic [WIDTH-1:0] chain [0:STEPS];

    assign chain[0] = state;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        assign chain[i+1] = {chain[i][WIDTH-2:0], ^(chain[i] & poly)};
    end

    assign next_state = chain[STEPS];

endmodule

// File: rtl/lfsr_stream_gen.sv
// LFSR word generator with a valid/ready output stream.
//   clk, rst_n       : clock, synchronous active-low reset
//   cfg_poly, seed   : tap mask (latched at start), seed value
//   seed_load        : load seed (honoured in IDLE/DONE/LOCK)
//   start, stop      : begin / abort generation (stop wins over start)
//   num_words        : words to emit, 0 = free-run (latched at start)
//   out_data/valid   : output word and its valid flag
//   out_ready        : consumer accepts the current word
//   busy, done       : running / word count reached
//   lockup           : state is all-zero, cleared by a nonzero seed_load
//   words_cnt        : words accepted since start
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEPS     = 1,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RST_STATE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cfg_poly,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_words,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic [CNT_W-1:0] words_cnt
);

    lfsr_fsm_t        fsm, fsm_nxt;
    logic [WIDTH-1:0] state, poly_q, stepped;
    logic [CNT_W-1:0] num_q, issued, cnt_inc;
    logic             load_seed, go, adv, lock_hit, hit_limit, hs;

    lfsr_step_unroll #(.WIDTH(WIDTH), .STEPS(STEPS)) u_step (
        .state      (state),
        .poly       (poly_q),
        .next_state (stepped)
    );

    assign cnt_inc = words_cnt + CNT_W'(1);

    always_comb begin
        fsm_nxt   = fsm;
        load_seed = 1'b0;
        go        = 1'b0;
        adv       = 1'b0;
        lock_hit  = 1'b0;
        hit_limit = 1'b0;
        hs        = out_valid && out_ready;
        busy      = (fsm == RUN);
        case (fsm)
            IDLE, DONE: begin
                if (seed_load) begin
                    load_seed = 1'b1;
                    if (seed == '0) fsm_nxt = LOCK;
                end
                // A zero seed loaded together with start still locks up.
                if (start && !stop && !(seed_load && seed == '0)) begin
                    go      = 1'b1;
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    fsm_nxt = IDLE;
                end else if ((!out_valid || out_ready) &&
                             (num_q == '0 || issued < num_q)) begin
                    // An all-zero successor is never emitted: park in LOCK.
                    if (stepped == '0) begin
                        lock_hit = 1'b1;
                        fsm_nxt  = LOCK;
                    end else begin
                        adv = 1'b1;
                    end
                end
                // Final handshake can never coincide with an advance, since
                // issued has already reached num_q by then.
                if (hs && num_q != '0 && cnt_inc == num_q) begin
                    hit_limit = 1'b1;
                    fsm_nxt   = DONE;
                end
            end
            LOCK: begin
                if (seed_load && seed != '0) begin
                    load_seed = 1'b1;
                    fsm_nxt   = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state     <= RST_STATE;
            poly_q    <= '0;
            num_q     <= '0;
            issued    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            lockup    <= 1'b0;
            words_cnt <= '0;
        end else begin
            fsm <= fsm_nxt;
            if (load_seed) begin
                state  <= seed;
                lockup <= (seed == '0);
                done   <= 1'b0;
            end
            // A word left pending by stop may still drain outside RUN.
            if (hs) begin
                out_valid <= 1'b0;
                words_cnt <= cnt_inc;
            end
            if (go) begin
                poly_q    <= cfg_poly;
                num_q     <= num_words;
                issued    <= '0;
                words_cnt <= '0;
                done      <= 1'b0;
            end
            if (adv) begin
                state     <= stepped;
                out_data  <= stepped;
                out_valid <= 1'b1;
                issued    <= issued + CNT_W'(1);
            end
            if (lock_hit) begin
                state  <= '0;
                lockup <= 1'b1;
            end
            if (hit_limit) done <= 1'b1;
        end
    end

endmodule
